fetch_sequencer: RTL and testbench

//  Program-counter and fetch controller that drives InstAddress of the instruction ROM.
//  - Starts a program on a Start pulse and steps the PC each cycle.
//  - Applies branch redirects and stalls from the core.
//  - Detects the all-ones halt word and raises Ack.
//  - Sits between the top-level Start/Ack handshake, the ROM and the decode stage.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_sequencer.sv | 83 ++++++++
 tb/tb_fetch_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fetch_state_t;

   // All-ones halt word; narrowed to the instruction width where it is compared.
   localparam logic [63:0] HALT_WORD = '1;

endpackage

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: starts on Start, steps/branches/stalls the PC,
// stops on the all-ones halt word and holds Ack until the next start.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned   A        = 10,
   parameter int unsigned   W        = 9,
   parameter int unsigned   CW       = 16,
   parameter logic [A-1:0]  START_PC = '0
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic [W-1:0]  InstOut,
   input  logic          Stall,
   input  logic          BranchTaken,
   input  logic [A-1:0]  Target,
   output logic [A-1:0]  InstAddress,
   output logic          InstValid,
   output logic          Ack,
   output logic [CW-1:0] CycleCount
);

   localparam logic [CW-1:0] CNT_MAX = '1;

   fetch_state_t  state_q, state_d;
   logic [A-1:0]  pc_q, pc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          halt_c;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q <= IDLE;
         pc_q    <= START_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state / next-PC select; halt beats stall, stall beats branch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      halt_c  = (InstOut == W'(HALT_WORD));

      unique case (state_q)
         IDLE, DONE: begin
            if (Start) begin
               state_d = RUN;
               pc_d    = START_PC;
               cnt_d   = '0;
            end
         end
         RUN: begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            if (halt_c) begin
               state_d = DONE;
            end else if (Stall) begin
               pc_d = pc_q;
            end else if (BranchTaken) begin
               pc_d = Target;
            end else begin
               pc_d = pc_q + A'(1);
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = START_PC;
            cnt_d   = '0;
         end
      endcase
   end

   assign InstAddress = pc_q;
   assign CycleCount  = cnt_q;
   assign InstValid   = (state_q == RUN);
   assign Ack         = (state_q == DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a default build and a narrow (A=4, CW=3) build,
// each beside a behavioural ROM, checked against expectations queued per step.
module tb_fetch_sequencer;

   localparam int unsigned A   = 10;
   localparam int unsigned W   = 9;
   localparam int unsigned CW  = 16;
   localparam int unsigned A2  = 4;
   localparam int unsigned CW2 = 3;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic          Reset, Start, Stall, BranchTaken;
   logic [A-1:0]  Target, InstAddress;
   logic [W-1:0]  InstOut;
   logic          InstValid, Ack;
   logic [CW-1:0] CycleCount;

   logic           Start2, Stall2, BranchTaken2;
   logic [A2-1:0]  Target2, InstAddress2;
   logic [W-1:0]   InstOut2;
   logic           InstValid2, Ack2;
   logic [CW2-1:0] CycleCount2;

   logic [W-1:0] rom  [0:(1<<A)-1];
   logic [W-1:0] rom2 [0:(1<<A2)-1];

   assign InstOut  = rom[InstAddress];
   assign InstOut2 = rom2[InstAddress2];

   fetch_sequencer #(.A(A), .W(W), .CW(CW)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .InstOut(InstOut), .Stall(Stall),
      .BranchTaken(BranchTaken), .Target(Target), .InstAddress(InstAddress),
      .InstValid(InstValid), .Ack(Ack), .CycleCount(CycleCount)
   );

   fetch_sequencer #(.A(A2), .W(W), .CW(CW2)) dut2 (
      .Clk(Clk), .Reset(Reset), .Start(Start2), .InstOut(InstOut2), .Stall(Stall2),
      .BranchTaken(BranchTaken2), .Target(Target2), .InstAddress(InstAddress2),
      .InstValid(InstValid2), .Ack(Ack2), .CycleCount(CycleCount2)
   );

   typedef struct {
      string       tag;
      logic [15:0] addr;
      logic        valid;
      logic        ack;
      logic [15:0] cnt;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input string what, input logic [15:0] obs,
                      input logic [15:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s.%s observed=%0d expected=%0d", tag, what, obs, expv);
      end
   endtask

   // One clock edge, then pop and compare whatever each instance was expected to show.
   task automatic tick();
      exp_t e;
      @(posedge Clk);
      #1;
      if (q1.size() > 0) begin
         e = q1.pop_front();
         chk(e.tag, "addr",  16'(InstAddress), e.addr);
         chk(e.tag, "valid", 16'(InstValid),   16'(e.valid));
         chk(e.tag, "ack",   16'(Ack),         16'(e.ack));
         chk(e.tag, "cnt",   16'(CycleCount),  e.cnt);
      end
      if (q2.size() > 0) begin
         e = q2.pop_front();
         chk(e.tag, "addr2",  16'(InstAddress2), e.addr);
         chk(e.tag, "valid2", 16'(InstValid2),   16'(e.valid));
         chk(e.tag, "ack2",   16'(Ack2),         16'(e.ack));
         chk(e.tag, "cnt2",   16'(CycleCount2),  e.cnt);
      end
   endtask

   task automatic st(input string tag, input int addr, input bit v, input bit a, input int cnt);
      exp_t e;
      e = '{tag, 16'(addr), v, a, 16'(cnt)};
      q1.push_back(e);
      tick();
   endtask

   task automatic st2(input string tag, input int addr, input bit v, input bit a, input int cnt);
      exp_t e;
      e = '{tag, 16'(addr), v, a, 16'(cnt)};
      q2.push_back(e);
      tick();
   endtask

   initial begin
      Reset = 1'b0; Start = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; Target = '0;
      Start2 = 1'b0; Stall2 = 1'b0; BranchTaken2 = 1'b0; Target2 = '0;
      for (int i = 0; i < (1<<A); i++)  rom[i]  = '0;
      for (int i = 0; i < (1<<A2); i++) rom2[i] = '0;

      // Reset state of both builds
      q2.push_back('{"rst2", 16'd0, 1'b0, 1'b0, 16'd0});
      st("rst", 0, 0, 0, 0);
      st("rst", 0, 0, 0, 0);
      Reset = 1'b1;
      st("idle_hold", 0, 0, 0, 0);

      // Straight-line program ending in the halt word
      rom[0] = 9'b000_001_100;
      rom[1] = 9'b000_101_000;
      rom[2] = 9'b010_101_010;
      rom[3] = 9'b001_001_100;
      rom[4] = 9'b1_1111_1111;
      Start = 1'b1;
      st("prog_start", 0, 1, 0, 0);
      Start = 1'b0;
      for (int k = 1; k <= 4; k++) st("prog_step", k, 1, 0, k);
      st("prog_halt", 4, 0, 1, 5);
      st("prog_done_hold", 4, 0, 1, 5);

      // Restart from DONE; a Start pulse mid-run must not restart
      Start = 1'b1;
      st("rerun_start", 0, 1, 0, 0);
      Start = 1'b0;
      st("rerun", 1, 1, 0, 1);
      Start = 1'b1;
      st("run_start_ignored", 2, 1, 0, 2);
      Start = 1'b0;
      st("rerun", 3, 1, 0, 3);
      st("rerun", 4, 1, 0, 4);
      st("rerun_halt", 4, 0, 1, 5);

      // Branch, stall, stall+branch, wrap at 1023, halt overriding stall/branch
      rom[4]   = '0;
      rom[700] = 9'h1FF;
      Start = 1'b1;
      st("br_start", 0, 1, 0, 0);
      Start = 1'b0;
      st("br_step", 1, 1, 0, 1);
      st("br_step", 2, 1, 0, 2);
      BranchTaken = 1'b1; Target = 10'd600;
      st("branch", 600, 1, 0, 3);
      BranchTaken = 1'b0;
      st("after_branch", 601, 1, 0, 4);
      Stall = 1'b1;
      st("stall", 601, 1, 0, 5);
      st("stall", 601, 1, 0, 6);
      Stall = 1'b0;
      st("stall_release", 602, 1, 0, 7);
      Stall = 1'b1; BranchTaken = 1'b1; Target = 10'd900;
      st("stall_beats_branch", 602, 1, 0, 8);
      Stall = 1'b0; BranchTaken = 1'b0;
      st("step", 603, 1, 0, 9);
      BranchTaken = 1'b1; Target = 10'd1022;
      st("branch_top", 1022, 1, 0, 10);
      BranchTaken = 1'b0;
      st("step_top", 1023, 1, 0, 11);
      st("wrap", 0, 1, 0, 12);
      st("after_wrap", 1, 1, 0, 13);
      BranchTaken = 1'b1; Target = 10'd700;
      st("branch_halt", 700, 1, 0, 14);
      Stall = 1'b1; BranchTaken = 1'b1; Target = 10'd5;
      st("halt_over_stall", 700, 0, 1, 15);
      Stall = 1'b0; BranchTaken = 1'b0;
      st("halt_hold", 700, 0, 1, 15);

      // Reset mid-run, held low three edges
      Start = 1'b1;
      st("rst_run_start", 0, 1, 0, 0);
      Start = 1'b0;
      st("rst_run", 1, 1, 0, 1);
      st("rst_run", 2, 1, 0, 2);
      Reset = 1'b0;
      for (int k = 0; k < 3; k++) st("rst_mid_run", 0, 0, 0, 0);
      Reset = 1'b1;
      st("rst_release", 0, 0, 0, 0);
      Start = 1'b1;
      st("start_after_rst", 0, 1, 0, 0);
      Start = 1'b0;

      // Narrow build: 15 wraps to 0, CycleCount saturates at 7
      rom2[9] = 9'h1FF;
      Start2 = 1'b1;
      st2("n_start", 0, 1, 0, 0);
      Start2 = 1'b0; BranchTaken2 = 1'b1; Target2 = 4'd14;
      st2("n_branch", 14, 1, 0, 1);
      BranchTaken2 = 1'b0;
      st2("n_step", 15, 1, 0, 2);
      for (int k = 0; k <= 9; k++) st2("n_wrap_sat", k, 1, 0, (k + 3 > 7) ? 7 : k + 3);
      st2("n_halt_sat", 9, 0, 1, 7);

      chk("scoreboard", "q1_left", 16'(q1.size()), 16'd0);
      chk("scoreboard", "q2_left", 16'(q2.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
